cv32e41s_dbg_trace_buf: RTL and testbench
=========================================

Name: cv32e41s_dbg_trace_buf

Overview:
- Parametrised debug trace buffer for simulation and FPGA bring-up.
- Sits beside the writeback stage and captures one decoded record per retired instruction into a circular buffer of DEPTH entries. A record holds the instruction, compressed flag, register-file read/write info and the illegal flag.
- Supports trigger-then-freeze with a programmable post-trigger window, plus a registered indexed readout port.
- Not synthesis-critical; no effect on core behaviour.

Parameters:
- REGFILE_NUM_READ_PORTS, 2, number of register-file read ports recorded per entry (1..3).
- DEPTH, 8, number of trace entries; power of two, >=2.
- POST_TRIGGER, 2, entries captured after trigger before freezing (0..DEPTH-1).
- IDXW, $clog2(DEPTH), derived; index/pointer width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- valid_i  in  1  instruction retires this cycle; capture a record.
- instr_i  in  32  instruction word.
- is_compressed_i  in  1  compressed-instruction flag.
- rf_re_i  in  REGFILE_NUM_READ_PORTS  register-file read enables.
- rf_raddr_i  in  5*REGFILE_NUM_READ_PORTS  packed read addresses; port i in bits [5i+4:5i].
- rf_we_i  in  1  register-file write enable.
- rf_waddr_i  in  5  register-file write address.
- illegal_insn_i  in  1  illegal-instruction flag.
- trigger_i  in  1  freeze request.
- clear_i  in  1  flush buffer and rearm.
- rd_req_i  in  1  read request.
- rd_idx_i  in  IDXW  logical index; 0 = oldest stored entry.
- rd_valid_o  out  1  read response valid.
- rd_hit_o  out  1  response refers to a stored entry.
- rd_instr_o  out  32  entry instruction.
- rd_opcode_o  out  7  entry instr[6:0].
- rd_compressed_o  out  1  entry compressed flag.
- rd_rf_re_o  out  REGFILE_NUM_READ_PORTS  entry read enables.
- rd_rf_raddr_o  out  5*REGFILE_NUM_READ_PORTS  entry read addresses.
- rd_rf_we_o  out  1  entry write enable.
- rd_rf_waddr_o  out  5  entry write address.
- rd_illegal_o  out  1  entry illegal flag.
- count_o  out  IDXW+1  number of valid entries (0..DEPTH).
- wrapped_o  out  1  sticky: at least one entry has been overwritten.
- frozen_o  out  1  state == FROZEN.
- illegal_cnt_o  out  16  saturating count of captured illegal instructions.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State goes to CAPTURE.
  - wptr=0, count_o=0, wrapped_o=0, illegal_cnt_o=0, post counter=0.
  - All rd_* outputs go to 0, including rd_valid_o and rd_hit_o.
  - Entry storage is not reset.
- States:
  - CAPTURE: each valid_i writes the record at wptr; wptr increments mod DEPTH; count_o saturates at DEPTH. Writing while count_o==DEPTH sets wrapped_o.
  - trigger_i in CAPTURE:
    - POST_TRIGGER>0: go to POST, post counter=POST_TRIGGER.
    - POST_TRIGGER==0: go to FROZEN.
    - A valid_i in the trigger cycle is still written; it is the last pre-trigger entry.
  - POST: each valid_i writes as in CAPTURE and decrements the post counter. The write that brings the counter to 0 moves the state to FROZEN on the same edge. trigger_i is ignored.
  - FROZEN: no writes, counters hold, trigger_i is ignored. Reads remain available.
- clear_i, any state:
  - Next cycle: CAPTURE, wptr=0, count_o=0, wrapped_o=0, illegal_cnt_o=0.
  - clear_i has priority over valid_i and trigger_i in the same cycle; that record is dropped.
- illegal_cnt_o increments on each written record with illegal_insn_i=1 and saturates at 0xFFFF. Records not written (FROZEN, or clear_i cycle) do not count.
- Read:
  - One-cycle latency. rd_req_i at cycle N gives rd_valid_o=1 at N+1.
  - rd_valid_o is 0 in any cycle following no request.
  - Physical slot = (wptr - count_o + rd_idx_i) mod DEPTH, using pre-update values at cycle N.
  - Data reflects storage before any write at cycle N.
  - rd_idx_i >= count_o: rd_hit_o=0 and all rd data fields 0.
  - rd_opcode_o = rd_instr_o[6:0].
- Back-to-back reads are allowed every cycle. A read concurrent with clear_i uses pre-clear state.
- Reset mid-POST or in FROZEN returns to CAPTURE with an empty buffer.

Test Plan:
- Reset, then 3 retires with instr 0x00000013, 0x00100093, 0x4501 (compressed=1) → count_o=3, wrapped_o=0; reading idx 0..2 returns them in order; idx 3 gives rd_hit_o=0 with data 0.
- DEPTH=8, 10 retires with instr=k for k=1..10 → count_o=8, wrapped_o=1; idx0 returns 3, idx7 returns 10.
- POST_TRIGGER=2: retire 1..4, trigger with retire 5, then retires 6,7,8 → frozen_o=1 after retire 7; count_o=7; idx6 returns 7; retire 8 dropped.
- POST_TRIGGER=0: trigger alone → frozen_o=1 next cycle; subsequent retires not captured; clear_i → frozen_o=0, count_o=0, next retire lands at idx0.
- Retires with illegal_insn_i=1 ×3 interleaved with legal ones → illegal_cnt_o=3; clear_i in the same cycle as an illegal retire → illegal_cnt_o=0, count_o=0.
- rf_re_i=2'b11, rf_raddr_i={5'd7,5'd3}, rf_we_i=1, rf_waddr_i=9 captured → readback matches exactly; read issued in same cycle as a write to that slot returns pre-write content.

Source files
------------

// File: rtl/cv32e41s_dbg_trace_buf.sv
// Debug trace buffer: circular capture of retired-instruction records with
// trigger-then-freeze and a registered indexed readout port.
module cv32e41s_dbg_trace_buf #(
  parameter int REGFILE_NUM_READ_PORTS = 2,
  parameter int DEPTH                  = 8,
  parameter int POST_TRIGGER           = 2,
  parameter int IDXW                   = $clog2(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  valid_i,
  input  logic [31:0]                           instr_i,
  input  logic                                  is_compressed_i,
  input  logic [REGFILE_NUM_READ_PORTS-1:0]     rf_re_i,
  input  logic [5*REGFILE_NUM_READ_PORTS-1:0]   rf_raddr_i,
  input  logic                                  rf_we_i,
  input  logic [4:0]                            rf_waddr_i,
  input  logic                                  illegal_insn_i,
  input  logic                                  trigger_i,
  input  logic                                  clear_i,
  input  logic                                  rd_req_i,
  input  logic [IDXW-1:0]                       rd_idx_i,
  output logic                                  rd_valid_o,
  output logic                                  rd_hit_o,
  output logic [31:0]                           rd_instr_o,
  output logic [6:0]                            rd_opcode_o,
  output logic                                  rd_compressed_o,
  output logic [REGFILE_NUM_READ_PORTS-1:0]     rd_rf_re_o,
  output logic [5*REGFILE_NUM_READ_PORTS-1:0]   rd_rf_raddr_o,
  output logic                                  rd_rf_we_o,
  output logic [4:0]                            rd_rf_waddr_o,
  output logic                                  rd_illegal_o,
  output logic [IDXW:0]                         count_o,
  output logic                                  wrapped_o,
  output logic                                  frozen_o,
  output logic [15:0]                           illegal_cnt_o
);

  localparam int NRP = REGFILE_NUM_READ_PORTS;
  localparam logic [IDXW:0]   L_FULL = (IDXW+1)'(DEPTH);
  localparam logic [IDXW-1:0] L_ONE  = IDXW'(1);

  typedef enum logic [1:0] {
    S_CAPTURE = 2'd0,
    S_POST    = 2'd1,
    S_FROZEN  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0]      instr;
    logic             comp;
    logic [NRP-1:0]   re;
    logic [5*NRP-1:0] raddr;
    logic             we;
    logic [4:0]       waddr;
    logic             ill;
  } entry_t;

  entry_t          r_mem [DEPTH];
  state_t          r_state;
  logic [IDXW-1:0] r_wptr;
  logic [IDXW:0]   r_count;
  logic [IDXW-1:0] r_post;
  logic            r_wrapped;
  logic            r_frozen;
  logic [15:0]     r_ill_cnt;
  logic            r_rd_valid;
  logic            r_rd_hit;
  entry_t          r_rd_entry;

  logic            w_wr;
  logic [IDXW-1:0] w_slot;
  logic            w_hit;
  entry_t          w_new;

  // clear_i drops the record of its cycle; nothing lands while frozen
  assign w_wr   = rst_n && valid_i && !clear_i && (r_state != S_FROZEN);
  assign w_slot = r_wptr - r_count[IDXW-1:0] + rd_idx_i;
  assign w_hit  = ({1'b0, rd_idx_i} < r_count);
  assign w_new  = '{instr: instr_i, comp: is_compressed_i, re: rf_re_i,
                    raddr: rf_raddr_i, we: rf_we_i, waddr: rf_waddr_i,
                    ill: illegal_insn_i};

  // Entry storage, deliberately without reset
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= w_new;
    end
  end

  // Capture FSM with pointers, occupancy and sticky status
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      r_state   <= S_CAPTURE;
      r_frozen  <= 1'b0;
      r_wptr    <= '0;
      r_count   <= '0;
      r_post    <= '0;
      r_wrapped <= 1'b0;
      r_ill_cnt <= 16'd0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + L_ONE;
        if (r_count != L_FULL) begin
          r_count <= r_count + (IDXW+1)'(1);
        end else begin
          r_wrapped <= 1'b1;
        end
        if (illegal_insn_i && (r_ill_cnt != 16'hFFFF)) begin
          r_ill_cnt <= r_ill_cnt + 16'd1;
        end
      end
      case (r_state)
        S_CAPTURE: begin
          if (trigger_i) begin
            if (POST_TRIGGER > 0) begin
              r_state <= S_POST;
              r_post  <= IDXW'(POST_TRIGGER);
            end else begin
              r_state  <= S_FROZEN;
              r_frozen <= 1'b1;
            end
          end
        end
        S_POST: begin
          if (w_wr) begin
            r_post <= r_post - L_ONE;
            if (r_post == L_ONE) begin
              r_state  <= S_FROZEN;
              r_frozen <= 1'b1;
            end
          end
        end
        S_FROZEN: begin
          r_frozen <= 1'b1;
        end
        default: begin
          r_state  <= S_CAPTURE;
          r_frozen <= 1'b0;
        end
      endcase
    end
  end

  // Registered readout; storage is sampled before this edge's write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_hit   <= 1'b0;
      r_rd_entry <= '0;
    end else if (rd_req_i) begin
      r_rd_valid <= 1'b1;
      r_rd_hit   <= w_hit;
      r_rd_entry <= w_hit ? r_mem[w_slot] : '0;
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_hit   <= 1'b0;
      r_rd_entry <= '0;
    end
  end

  assign rd_valid_o      = r_rd_valid;
  assign rd_hit_o        = r_rd_hit;
  assign rd_instr_o      = r_rd_entry.instr;
  assign rd_opcode_o     = r_rd_entry.instr[6:0];
  assign rd_compressed_o = r_rd_entry.comp;
  assign rd_rf_re_o      = r_rd_entry.re;
  assign rd_rf_raddr_o   = r_rd_entry.raddr;
  assign rd_rf_we_o      = r_rd_entry.we;
  assign rd_rf_waddr_o   = r_rd_entry.waddr;
  assign rd_illegal_o    = r_rd_entry.ill;
  assign count_o         = r_count;
  assign wrapped_o       = r_wrapped;
  assign frozen_o        = r_frozen;
  assign illegal_cnt_o   = r_ill_cnt;

endmodule

// File: tb/tb_cv32e41s_dbg_trace_buf.sv
// Directed self-checking bench: one instance with POST_TRIGGER=2 and a
// second with POST_TRIGGER=0, both driven by the same stimulus.
module tb_cv32e41s_dbg_trace_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, is_compressed_i, rf_we_i, illegal_insn_i;
  logic        trigger_i, clear_i, rd_req_i;
  logic [31:0] instr_i;
  logic [1:0]  rf_re_i;
  logic [9:0]  rf_raddr_i;
  logic [4:0]  rf_waddr_i;
  logic [2:0]  rd_idx_i;

  logic        rd_valid_o, rd_hit_o, rd_compressed_o, rd_rf_we_o, rd_illegal_o;
  logic [31:0] rd_instr_o;
  logic [6:0]  rd_opcode_o;
  logic [1:0]  rd_rf_re_o;
  logic [9:0]  rd_rf_raddr_o;
  logic [4:0]  rd_rf_waddr_o;
  logic [3:0]  count_o;
  logic        wrapped_o, frozen_o;
  logic [15:0] illegal_cnt_o;

  logic        z_rd_valid, z_rd_hit, z_rd_compressed, z_rd_rf_we, z_rd_illegal;
  logic [31:0] z_rd_instr;
  logic [6:0]  z_rd_opcode;
  logic [1:0]  z_rd_rf_re;
  logic [9:0]  z_rd_rf_raddr;
  logic [4:0]  z_rd_rf_waddr;
  logic [3:0]  z_count;
  logic        z_wrapped, z_frozen;
  logic [15:0] z_illegal_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cv32e41s_dbg_trace_buf #(.REGFILE_NUM_READ_PORTS(2), .DEPTH(8), .POST_TRIGGER(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .instr_i(instr_i),
    .is_compressed_i(is_compressed_i), .rf_re_i(rf_re_i), .rf_raddr_i(rf_raddr_i),
    .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i), .illegal_insn_i(illegal_insn_i),
    .trigger_i(trigger_i), .clear_i(clear_i), .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i),
    .rd_valid_o(rd_valid_o), .rd_hit_o(rd_hit_o), .rd_instr_o(rd_instr_o),
    .rd_opcode_o(rd_opcode_o), .rd_compressed_o(rd_compressed_o), .rd_rf_re_o(rd_rf_re_o),
    .rd_rf_raddr_o(rd_rf_raddr_o), .rd_rf_we_o(rd_rf_we_o), .rd_rf_waddr_o(rd_rf_waddr_o),
    .rd_illegal_o(rd_illegal_o), .count_o(count_o), .wrapped_o(wrapped_o),
    .frozen_o(frozen_o), .illegal_cnt_o(illegal_cnt_o)
  );

  cv32e41s_dbg_trace_buf #(.REGFILE_NUM_READ_PORTS(2), .DEPTH(8), .POST_TRIGGER(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .instr_i(instr_i),
    .is_compressed_i(is_compressed_i), .rf_re_i(rf_re_i), .rf_raddr_i(rf_raddr_i),
    .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i), .illegal_insn_i(illegal_insn_i),
    .trigger_i(trigger_i), .clear_i(clear_i), .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i),
    .rd_valid_o(z_rd_valid), .rd_hit_o(z_rd_hit), .rd_instr_o(z_rd_instr),
    .rd_opcode_o(z_rd_opcode), .rd_compressed_o(z_rd_compressed), .rd_rf_re_o(z_rd_rf_re),
    .rd_rf_raddr_o(z_rd_rf_raddr), .rd_rf_we_o(z_rd_rf_we), .rd_rf_waddr_o(z_rd_rf_waddr),
    .rd_illegal_o(z_rd_illegal), .count_o(z_count), .wrapped_o(z_wrapped),
    .frozen_o(z_frozen), .illegal_cnt_o(z_illegal_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] ins, input logic comp, input logic ill);
    valid_i = 1'b1; instr_i = ins; is_compressed_i = comp; illegal_insn_i = ill;
    tick();
    valid_i = 1'b0; instr_i = 32'd0; is_compressed_i = 1'b0; illegal_insn_i = 1'b0;
  endtask

  task automatic rd(input logic [2:0] idx);
    rd_req_i = 1'b1; rd_idx_i = idx;
    tick();
    rd_req_i = 1'b0; rd_idx_i = 3'd0;
  endtask

  task automatic clr();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; instr_i = 32'd0; is_compressed_i = 1'b0;
    rf_re_i = 2'd0; rf_raddr_i = 10'd0; rf_we_i = 1'b0; rf_waddr_i = 5'd0;
    illegal_insn_i = 1'b0; trigger_i = 1'b0; clear_i = 1'b0;
    rd_req_i = 1'b0; rd_idx_i = 3'd0;
    tick(); tick();
    chk("rst_count", count_o, 64'd0);
    chk("rst_wrapped", wrapped_o, 64'd0);
    chk("rst_frozen", frozen_o, 64'd0);
    chk("rst_illcnt", illegal_cnt_o, 64'd0);
    chk("rst_rdvalid", rd_valid_o, 64'd0);
    chk("rst_rddata", {rd_hit_o, rd_instr_o}, 64'd0);
    rst_n = 1'b1;

    // three retires, in-order readback, out-of-range index
    retire(32'h0000_0013, 1'b0, 1'b0);
    retire(32'h0010_0093, 1'b0, 1'b0);
    retire(32'h0000_4501, 1'b1, 1'b0);
    chk("t1_count", count_o, 64'd3);
    chk("t1_wrapped", wrapped_o, 64'd0);
    rd(3'd0);
    chk("t1_rd0_valid", rd_valid_o, 64'd1);
    chk("t1_rd0_hit", rd_hit_o, 64'd1);
    chk("t1_rd0_instr", rd_instr_o, 64'h13);
    chk("t1_rd0_comp", rd_compressed_o, 64'd0);
    rd(3'd1);
    chk("t1_rd1_instr", rd_instr_o, 64'h0010_0093);
    chk("t1_rd1_opcode", rd_opcode_o, 64'h13);
    rd(3'd2);
    chk("t1_rd2_instr", rd_instr_o, 64'h4501);
    chk("t1_rd2_comp", rd_compressed_o, 64'd1);
    chk("t1_rd2_opcode", rd_opcode_o, 64'h01);
    rd(3'd3);
    chk("t1_rd3_valid", rd_valid_o, 64'd1);
    chk("t1_rd3_hit", rd_hit_o, 64'd0);
    chk("t1_rd3_instr", rd_instr_o, 64'd0);
    tick();
    chk("t1_noreq_valid", rd_valid_o, 64'd0);

    // wrap-around
    clr();
    chk("t2_clr_count", count_o, 64'd0);
    for (int k = 1; k <= 10; k++) retire(32'(k), 1'b0, 1'b0);
    chk("t2_count", count_o, 64'd8);
    chk("t2_wrapped", wrapped_o, 64'd1);
    rd(3'd0);
    chk("t2_rd0_instr", rd_instr_o, 64'd3);
    rd(3'd7);
    chk("t2_rd7_instr", rd_instr_o, 64'd10);

    // trigger with POST_TRIGGER=2
    clr();
    for (int k = 1; k <= 4; k++) retire(32'(k), 1'b0, 1'b0);
    trigger_i = 1'b1;
    retire(32'd5, 1'b0, 1'b0);
    trigger_i = 1'b0;
    retire(32'd6, 1'b0, 1'b0);
    chk("t3_frozen_after6", frozen_o, 64'd0);
    retire(32'd7, 1'b0, 1'b0);
    chk("t3_frozen_after7", frozen_o, 64'd1);
    retire(32'd8, 1'b0, 1'b0);
    chk("t3_count", count_o, 64'd7);
    rd(3'd6);
    chk("t3_rd6_instr", rd_instr_o, 64'd7);
    rd(3'd7);
    chk("t3_rd7_hit", rd_hit_o, 64'd0);

    // trigger alone with POST_TRIGGER=0 (u_dut0); u_dut goes to POST instead
    clr();
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    chk("t4_z_frozen", z_frozen, 64'd1);
    chk("t4_post_not_frozen", frozen_o, 64'd0);
    retire(32'hAA, 1'b0, 1'b0);
    chk("t4_z_count_frozen", z_count, 64'd0);
    chk("t4_count_post", count_o, 64'd1);
    clr();
    chk("t4_z_unfrozen", z_frozen, 64'd0);
    chk("t4_z_count_clr", z_count, 64'd0);
    retire(32'hBB, 1'b0, 1'b0);
    chk("t4_z_count", z_count, 64'd1);
    rd(3'd0);
    chk("t4_z_rd_hit", {z_rd_valid, z_rd_hit}, 64'd3);
    chk("t4_z_rd_instr", z_rd_instr, 64'hBB);
    chk("t4_z_rd_opcode", z_rd_opcode, 64'h3B);
    chk("t4_z_rest", {z_rd_rf_re, z_rd_rf_raddr, z_rd_rf_we, z_rd_rf_waddr,
                      z_rd_illegal, z_rd_compressed, z_wrapped, z_illegal_cnt}, 64'd0);

    // illegal counter, clear priority, read concurrent with clear
    clr();
    retire(32'hA1, 1'b0, 1'b1);
    retire(32'hB2, 1'b0, 1'b0);
    retire(32'hC3, 1'b0, 1'b1);
    retire(32'hD4, 1'b0, 1'b0);
    retire(32'hE5, 1'b0, 1'b1);
    chk("t5_illcnt", illegal_cnt_o, 64'd3);
    chk("t5_count", count_o, 64'd5);
    clear_i = 1'b1; rd_req_i = 1'b1; rd_idx_i = 3'd0;
    retire(32'hF6, 1'b0, 1'b1);
    clear_i = 1'b0; rd_req_i = 1'b0;
    chk("t5_clr_illcnt", illegal_cnt_o, 64'd0);
    chk("t5_clr_count", count_o, 64'd0);
    chk("t5_clr_rd_instr", rd_instr_o, 64'hA1);
    chk("t5_clr_rd_ill", {rd_hit_o, rd_illegal_o}, 64'd3);

    // register-file fields and read-before-write on the same slot
    clr();
    rf_re_i = 2'b11; rf_raddr_i = {5'd7, 5'd3}; rf_we_i = 1'b1; rf_waddr_i = 5'd9;
    retire(32'h33, 1'b0, 1'b0);
    rf_re_i = 2'b00; rf_raddr_i = 10'd0; rf_we_i = 1'b0; rf_waddr_i = 5'd0;
    rd(3'd0);
    chk("t6_rf_re", rd_rf_re_o, 64'd3);
    chk("t6_rf_raddr", rd_rf_raddr_o, 64'h0E3);
    chk("t6_rf_we", rd_rf_we_o, 64'd1);
    chk("t6_rf_waddr", rd_rf_waddr_o, 64'd9);
    for (int k = 1; k <= 7; k++) retire(32'h100 + 32'(k), 1'b0, 1'b0);
    chk("t6_full_count", count_o, 64'd8);
    chk("t6_full_wrapped", wrapped_o, 64'd0);
    rd_req_i = 1'b1; rd_idx_i = 3'd0;
    retire(32'h999, 1'b0, 1'b0);
    rd_req_i = 1'b0;
    chk("t6_prewrite_instr", rd_instr_o, 64'h33);
    chk("t6_prewrite_waddr", rd_rf_waddr_o, 64'd9);
    chk("t6_wrapped", wrapped_o, 64'd1);
    rd(3'd7);
    chk("t6_newest_instr", rd_instr_o, 64'h999);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
